fnd_scan_periph: RTL and testbench

FND_SCAN_PERIPH -- requirements
Module: fnd_scan_periph

---
 rtl/fnd_pkg.sv | 25 ++
 rtl/fnd_seg_decoder.sv | 13 +
 rtl/fnd_scan_periph.sv | 132 +++++++++++++
 tb/tb_fnd_scan_periph.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared definitions for the FND scan peripheral.
//   reg_sel_e  - register select decoded from PADDR[3:2]
//   FCR_EN/LZB - bit positions inside the control register
//   SEG_TABLE  - hex-to-7-segment table, active-low, segments a..g = bits 0..6
package fnd_pkg;

  typedef enum logic [1:0] {
    REG_FCR = 2'd0,   // control: EN, LZB
    REG_FMR = 2'd1,   // digit enable mask
    REG_FDR = 2'd2,   // packed digit nibbles
    REG_FPR = 2'd3    // decimal-point mask
  } reg_sel_e;

  localparam int FCR_EN  = 0;
  localparam int FCR_LZB = 1;

  // Entry n holds the segment code for nibble value n (packed, index 15 first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
    7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/fnd_seg_decoder.sv
// fnd_seg_decoder: combinational nibble to active-low 7-segment code.
//   nibble in  4  hex digit value
//   seg    out 7  segments a..g = bits 0..6, active-low
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/fnd_scan_periph.sv
// fnd_scan_periph: APB-programmed multiplexed 7-segment display scanner.
//   PCLK/PRESET        clock, asynchronous active-high reset
//   PADDR..PREADY      zero-wait-state APB slave, four word registers
//   fnd_comm [ND-1:0]  digit select, active-low, registered
//   fnd_font [7:0]     segments a..g + dp (bit 7), active-low, registered
module fnd_scan_periph
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 100_000
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [3:0]            PADDR,
  input  logic [31:0]           PWDATA,
  input  logic                  PWRITE,
  input  logic                  PENABLE,
  input  logic                  PSEL,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic [NUM_DIGITS-1:0] fnd_comm,
  output logic [7:0]            fnd_font
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int DW    = 4 * NUM_DIGITS;

  logic [1:0]            fcr;
  logic [NUM_DIGITS-1:0] fmr;
  logic [DW-1:0]         fdr;
  logic [NUM_DIGITS-1:0] fpr;

  logic en, lzb, access, wr;
  reg_sel_e sel;

  assign en     = fcr[FCR_EN];
  assign lzb    = fcr[FCR_LZB];
  assign sel    = reg_sel_e'(PADDR[3:2]);
  assign access = PSEL & PENABLE;
  assign wr     = access & PWRITE;
  assign PREADY = access;

  // ---------------- APB register file ----------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      fcr <= '0;
      fmr <= '0;
      fdr <= '0;
      fpr <= '0;
    end else if (wr) begin
      case (sel)
        REG_FCR: fcr <= PWDATA[1:0];
        REG_FMR: fmr <= PWDATA[NUM_DIGITS-1:0];
        REG_FDR: fdr <= PWDATA[DW-1:0];
        REG_FPR: fpr <= PWDATA[NUM_DIGITS-1:0];
        default: ;
      endcase
    end
  end

  // Read data is zero-extended and only driven during a selected read.
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (sel)
        REG_FCR: PRDATA[1:0]            = fcr;
        REG_FMR: PRDATA[NUM_DIGITS-1:0] = fmr;
        REG_FDR: PRDATA[DW-1:0]         = fdr;
        REG_FPR: PRDATA[NUM_DIGITS-1:0] = fpr;
        default: PRDATA = '0;
      endcase
    end
  end

  // ---------------- prescaler and digit index ----------------
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             tick;

  assign tick = (cnt == CNT_W'(CLK_DIV - 1));

  // Held at zero while disabled so re-enabling always starts from digit 0.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt <= '0;
      idx <= '0;
    end else if (!en) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // ---------------- per-digit decode ----------------
  logic [NUM_DIGITS-1:0][6:0] seg_all;
  logic [NUM_DIGITS-1:0]      lz_blank;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    fnd_seg_decoder u_dec (
      .nibble (fdr[4*g +: 4]),
      .seg    (seg_all[g])
    );
    // Digit g is a leading zero when it and every more significant nibble is 0.
    if (g == 0) begin : g_lsd
      assign lz_blank[g] = 1'b0;
    end else begin : g_msd
      assign lz_blank[g] = lzb && (fdr[DW-1:4*g] == '0);
    end
  end

  // ---------------- registered display outputs ----------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      fnd_comm <= '1;
      fnd_font <= 8'hFF;
    end else begin
      fnd_comm <= '1;
      fnd_font <= 8'hFF;
      if (en && fmr[idx]) begin
        fnd_comm[idx] <= 1'b0;
        if (!lz_blank[idx])
          fnd_font <= {~fpr[idx], seg_all[idx]};
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_periph.sv
// tb_fnd_scan_periph: directed bench with a slot-arithmetic reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_fnd_scan_periph;

  localparam int ND = 4;
  localparam int CD = 4;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic [3:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0, PENABLE = 1'b0, PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [ND-1:0] fnd_comm;
  logic [7:0]  fnd_font;

  always #5 PCLK = ~PCLK;

  fnd_scan_periph #(.NUM_DIGITS(ND), .CLK_DIV(CD)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
    .PREADY(PREADY), .fnd_comm(fnd_comm), .fnd_font(fnd_font)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Displayed digit = (cycles since enable / CD) mod ND; outputs lag state by one edge.
  logic [7:0] seg8 [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [1:0]  m_fcr;
  logic [3:0]  m_fmr, m_fpr;
  logic [15:0] m_fdr;
  int          m_t = 0;
  logic [3:0]  exp_c = 4'hF;
  logic [7:0]  exp_f = 8'hFF;
  bit          mon_on = 1'b0;

  function automatic logic [3:0] mdl_comm();
    int i;
    i = (m_t / CD) % ND;
    if (!m_fcr[0] || !m_fmr[i]) return 4'hF;
    return ~(4'b0001 << i);
  endfunction

  function automatic logic [7:0] mdl_font();
    int i;
    logic [3:0] nib;
    i = (m_t / CD) % ND;
    if (!m_fcr[0] || !m_fmr[i]) return 8'hFF;
    if (m_fcr[1] && i > 0 && (m_fdr >> (4 * i)) == 16'h0) return 8'hFF;
    nib = m_fdr[4*i +: 4];
    return {~m_fpr[i], seg8[nib][6:0]};
  endfunction

  logic wr_now, new_en;
  assign wr_now = PSEL && PENABLE && PWRITE;
  assign new_en = (wr_now && PADDR[3:2] == 2'd0) ? PWDATA[0] : m_fcr[0];

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      m_fcr <= '0; m_fmr <= '0; m_fdr <= '0; m_fpr <= '0;
      m_t <= 0;
      exp_c <= 4'hF;
      exp_f <= 8'hFF;
    end else begin
      exp_c <= mdl_comm();
      exp_f <= mdl_font();
      if (wr_now) begin
        case (PADDR[3:2])
          2'd0: m_fcr <= PWDATA[1:0];
          2'd1: m_fmr <= PWDATA[3:0];
          2'd2: m_fdr <= PWDATA[15:0];
          default: m_fpr <= PWDATA[3:0];
        endcase
      end
      m_t <= (m_fcr[0] && new_en) ? m_t + 1 : 0;
    end
  end

  always @(negedge PCLK) begin
    if (mon_on) begin
      chk("mdl_comm", {28'h0, fnd_comm}, {28'h0, exp_c});
      chk("mdl_font", {24'h0, fnd_font}, {24'h0, exp_f});
    end
  end

  // ---------------- APB tasks ----------------
  task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {a, 2'b00}; PWDATA = d;
    #1 chk("pready_setup_wr", {31'h0, PREADY}, 32'h0);
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 chk("pready_access_wr", {31'h0, PREADY}, 32'h1);
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {a, 2'b00};
    #1 chk("pready_setup_rd", {31'h0, PREADY}, 32'h0);
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 chk("pready_access_rd", {31'h0, PREADY}, 32'h1);
    chk(name, PRDATA, exp);
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
    #1 chk("prdata_idle", PRDATA, 32'h0);
  endtask

  // Checks n slots of CD cycles each, starting at the edge after an enabling write.
  task automatic check_slots(input logic [3:0][3:0] cs, input logic [3:0][7:0] fs,
                             input int nslots, input string tag);
    for (int s = 0; s < nslots; s++) begin
      for (int k = 0; k < CD; k++) begin
        @(posedge PCLK);
        #1;
        chk($sformatf("%s slot%0d comm", tag, s), {28'h0, fnd_comm}, {28'h0, cs[s % ND]});
        chk($sformatf("%s slot%0d font", tag, s), {24'h0, fnd_font}, {24'h0, fs[s % ND]});
      end
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int r = 0; r < 4; r++) apb_read(2'(r), 32'h0, $sformatf("%s reg%0d", tag, r));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1 PRESET = 1'b1;
    @(posedge PCLK);
    mon_on = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    #1;
    chk("rst comm", {28'h0, fnd_comm}, 32'hF);
    chk("rst font", {24'h0, fnd_font}, 32'hFF);
    chk("rst prdata", PRDATA, 32'h0);
    chk("rst pready", {31'h0, PREADY}, 32'h0);
    read_all_zero("rst");

    // Basic scan, 8 slots to show the wrap back to digit 0.
    apb_write(2'd2, 32'h4321);
    apb_write(2'd1, 32'hF);
    apb_write(2'd0, 32'h1);
    check_slots({4'h7, 4'hB, 4'hD, 4'hE}, {8'h99, 8'hB0, 8'hA4, 8'hF9}, 8, "scan");

    // Digit mask and decimal point.
    apb_write(2'd0, 32'h0);
    apb_write(2'd1, 32'h5);
    apb_write(2'd3, 32'h1);
    apb_write(2'd0, 32'h1);
    check_slots({4'hF, 4'hB, 4'hF, 4'hE}, {8'hFF, 8'hB0, 8'hFF, 8'h79}, 4, "mask");

    // Leading-zero blanking.
    apb_write(2'd0, 32'h0);
    apb_write(2'd1, 32'hF);
    apb_write(2'd3, 32'h0);
    apb_write(2'd2, 32'h0050);
    apb_write(2'd0, 32'h3);
    check_slots({4'h7, 4'hB, 4'hD, 4'hE}, {8'hFF, 8'hFF, 8'h92, 8'hC0}, 4, "lzb");
    apb_write(2'd2, 32'h0);          // applied mid-scan, no restart
    repeat (2 * CD * ND) @(posedge PCLK);
    apb_write(2'd0, 32'h0);
    apb_write(2'd0, 32'h3);
    check_slots({4'h7, 4'hB, 4'hD, 4'hE}, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4, "lzb0");

    // Disable in the middle of slot 2, then restart.
    apb_write(2'd0, 32'h0);
    apb_write(2'd2, 32'h4321);
    apb_write(2'd0, 32'h1);
    repeat (8) @(posedge PCLK);
    apb_write(2'd0, 32'h0);
    chk("dis before comm", {28'h0, fnd_comm}, 32'hB);
    chk("dis before font", {24'h0, fnd_font}, 32'hB0);
    @(posedge PCLK); #1;
    chk("dis after comm", {28'h0, fnd_comm}, 32'hF);
    chk("dis after font", {24'h0, fnd_font}, 32'hFF);
    apb_write(2'd0, 32'h1);
    check_slots({4'h7, 4'hB, 4'hD, 4'hE}, {8'h99, 8'hB0, 8'hA4, 8'hF9}, 4, "restart");

    // Register width masking and reset mid-scan.
    apb_write(2'd2, 32'hDEADBEEF);
    apb_read(2'd2, 32'h0000BEEF, "fdr trunc");
    apb_write(2'd1, 32'hFFFF_FFFF);
    apb_read(2'd1, 32'h0000000F, "fmr trunc");
    repeat (5) @(posedge PCLK);
    #3 PRESET = 1'b1;
    #1;
    chk("arst comm", {28'h0, fnd_comm}, 32'hF);
    chk("arst font", {24'h0, fnd_font}, 32'hFF);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    read_all_zero("arst");
    repeat (3 * CD * ND) @(posedge PCLK);
    #1;
    chk("arst stays off comm", {28'h0, fnd_comm}, 32'hF);
    chk("arst stays off font", {24'h0, fnd_font}, 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
